// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Holds the RV32I load/store funct3 widths, the error codes reported with done,
// and the three-state transaction FSM encoding.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Purpose: byte-lane steering for stores, extraction/extension for loads, legality decode.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: is_load_i/is_store_i/funct3_i/addr_lo_i describe the access; store_data_i and
// rdata_i are the raw rs2 and bus read words; outputs are strobes, lane-replicated
// write data, the extended load value and the illegal/misaligned flags.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        illegal_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        illegal_o = 1'b0;
        if (is_load_i && is_store_i) begin
            illegal_o = 1'b1;
        end else if (is_load_i) begin
            illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else if (is_store_i) begin
            illegal_o = !(funct3_i inside {F3_B, F3_H, F3_W});
        end
    end

    // funct3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        case (funct3_i[1:0])
            2'b01:   misaligned_o = addr_lo_i[0];
            2'b10:   misaligned_o = (addr_lo_i != 2'b00);
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = store_data_i;
        case (funct3_i)
            F3_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            F3_H: begin
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
            end
            F3_W:    wstrb_o = 4'b1111;
            default: wstrb_o = 4'b0000;
        endcase
        if (!is_store_i) begin
            wstrb_o = 4'b0000;
        end
    end

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data_o = {{16{half_v[15]}}, half_v};
            F3_W:    load_data_o = rdata_i;
            F3_BU:   load_data_o = {24'h0, byte_v};
            F3_HU:   load_data_o = {16'h0, half_v};
            default: load_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: turns an ALU effective address into one word-aligned data-memory transaction.
// Latency: done 2 cycles after start with immediate mem_ready; 1 cycle on decode errors.
// Backpressure: busy stalls the core; mem_req is held until mem_ready or timeout.
// Ports: start/is_load/is_store/funct3/addr/store_data issue an access; busy/done/
// load_data/err report it; mem_* is the single-beat data-memory bus.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // Keep the counter at least one bit wide when the timeout is disabled.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  err_q, err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        issue;
    logic        timeout_hit;

    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] req_load_unused;
    logic        req_illegal;
    logic        req_misaligned;

    logic [3:0]  rsp_wstrb_unused;
    logic [31:0] rsp_wdata_unused;
    logic [31:0] rsp_load;
    logic        rsp_illegal_unused;
    logic        rsp_misaligned_unused;

    // Request path: decodes the live issue inputs in IDLE.
    lsu_align u_align_req (
        .is_load_i    (is_load),
        .is_store_i   (is_store),
        .funct3_i     (funct3),
        .addr_lo_i    (addr[1:0]),
        .store_data_i (store_data),
        .rdata_i      (32'h0),
        .wstrb_o      (req_wstrb),
        .wdata_o      (req_wdata),
        .load_data_o  (req_load_unused),
        .illegal_o    (req_illegal),
        .misaligned_o (req_misaligned)
    );

    // Response path: extracts the load value from mem_rdata using the registered access.
    lsu_align u_align_rsp (
        .is_load_i    (!mem_we_q),
        .is_store_i   (mem_we_q),
        .funct3_i     (funct3_q),
        .addr_lo_i    (addr_lo_q),
        .store_data_i (32'h0),
        .rdata_i      (mem_rdata),
        .wstrb_o      (rsp_wstrb_unused),
        .wdata_o      (rsp_wdata_unused),
        .load_data_o  (rsp_load),
        .illegal_o    (rsp_illegal_unused),
        .misaligned_o (rsp_misaligned_unused)
    );

    // A start with neither op flag set is not an access and is dropped.
    assign issue       = start && (is_load || is_store);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + CNT_W'(1)) == CNT_LIMIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = (req_illegal || req_misaligned) ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        load_data_d = load_data_q;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    if (req_illegal) begin
                        // Illegal op outranks misalignment.
                        done_d      = 1'b1;
                        err_d       = ERR_ILLEGAL;
                        load_data_d = 32'h0;
                    end else if (req_misaligned) begin
                        done_d      = 1'b1;
                        err_d       = ERR_MISALIGN;
                        load_data_d = 32'h0;
                    end else begin
                        funct3_d    = funct3;
                        addr_lo_d   = addr[1:0];
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = req_wstrb;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    mem_req_d   = 1'b0;
                    done_d      = 1'b1;
                    err_d       = ERR_NONE;
                    load_data_d = mem_we_q ? 32'h0 : rsp_load;
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    done_d      = 1'b1;
                    err_d       = ERR_TIMEOUT;
                    load_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            load_data_q <= 32'h0;
            err_q       <= ERR_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign load_data = load_data_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus beats
// and completions into queues; a negedge monitor pops and compares them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done;
    logic [31:0] load_data;
    logic [1:0]  err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ld;
        logic [1:0]  err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wd;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: bus beat on accept, completion on done.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ready) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_accept", 32'd1, 32'd0);
            end else begin
                bus_t b;
                b = bus_q.pop_front();
                chk("mem_addr", mem_addr, b.addr);
                chk("mem_we", {31'h0, mem_we}, {31'h0, b.we});
                chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, b.strb});
                if (b.we) chk("mem_wdata", mem_wdata, b.wd);
            end
        end
        if (done) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("load_data", load_data, r.ld);
                chk("err", {30'h0, err}, {30'h0, r.err});
            end
        end
    end

    // Issue one access from an IDLE cycle (called at posedge+1) and drive the bus.
    task automatic access(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int dly, input bit bus, input logic [3:0] xstrb,
                          input logic [31:0] xwd, input logic [31:0] xld, input logic [1:0] xerr,
                          input int xcyc, input int xreq, input bit poke);
        resp_t r;
        bus_t  b;
        int    cyc;
        int    reqs;
        r.ld  = xld;
        r.err = xerr;
        resp_q.push_back(r);
        if (bus) begin
            b.addr = {a[31:2], 2'b00};
            b.we   = st;
            b.strb = xstrb;
            b.wd   = xwd;
            bus_q.push_back(b);
        end
        is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = wd; mem_rdata = rd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        reqs = 0;
        while (!done && cyc < 100) begin
            if (mem_req) reqs++;
            mem_ready = bus && (cyc - 1 >= dly);
            if (poke && cyc == 1) begin
                start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h300;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_ready = 1'b0;
        chk({nm, "_done_cycle"}, cyc, xcyc);
        chk({nm, "_req_cycles"}, reqs, xreq);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #3;
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_err", {30'h0, err}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        //      name      ld    st    f3      addr         wdata         rdata        dly bus strb     xwd           xld           xerr   cyc req poke
        access("sw",     1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        2'b00, 2, 1, 0);
        access("sb",     1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,        2'b00, 2, 1, 0);
        access("sh",     1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,        0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0,        2'b00, 2, 1, 0);
        access("lb",     1'b1, 1'b0, 3'b000, 32'h202, 32'h0,        32'h12803456, 0, 1, 4'b0000, 32'h0,        32'hFFFFFF80, 2'b00, 2, 1, 0);
        access("lbu",    1'b1, 1'b0, 3'b100, 32'h202, 32'h0,        32'h12803456, 0, 1, 4'b0000, 32'h0,        32'h00000080, 2'b00, 2, 1, 0);
        access("lhu",    1'b1, 1'b0, 3'b101, 32'h202, 32'h0,        32'h12803456, 0, 1, 4'b0000, 32'h0,        32'h00001280, 2'b00, 2, 1, 0);
        access("lh",     1'b1, 1'b0, 3'b001, 32'h200, 32'h0,        32'h12808001, 0, 1, 4'b0000, 32'h0,        32'hFFFF8001, 2'b00, 2, 1, 0);
        access("lw_dly", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 2, 1, 4'b0000, 32'h0,        32'hCAFEF00D, 2'b00, 4, 3, 0);
        access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b01, 1, 0, 0);
        access("sh_mis", 1'b0, 1'b1, 3'b001, 32'h103, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b01, 1, 0, 0);
        access("ld_011", 1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b11, 1, 0, 0);
        access("ld_pri", 1'b1, 1'b0, 3'b011, 32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b11, 1, 0, 0);
        access("both",   1'b1, 1'b1, 3'b000, 32'h100, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b11, 1, 0, 0);
        access("st_100", 1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        2'b11, 1, 0, 0);
        access("tmo",    1'b1, 1'b0, 3'b010, 32'h500, 32'h0,        32'h0,      999, 0, 4'b0000, 32'h0,        32'h0,        2'b10, 5, 4, 0);
        access("poke",   1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'h11223344, 2, 1, 4'b0000, 32'h0,        32'h11223344, 2'b00, 4, 3, 1);

        // Start with neither op flag is ignored.
        is_load = 1'b0; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("noop_busy1", {31'h0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("noop_busy2", {31'h0, busy}, 32'd0);

        // Reset during REQ drops mem_req asynchronously; late ready is ignored.
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("rq_mem_req", {31'h0, mem_req}, 32'd1);
        chk("rq_busy", {31'h0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("arst_busy", {31'h0, busy}, 32'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        chk("post_rst_busy", {31'h0, busy}, 32'd0);
        chk("post_rst_mem_req", {31'h0, mem_req}, 32'd0);

        access("after_rst", 1'b0, 1'b1, 3'b010, 32'h600, 32'h01020304, 32'h0, 0, 1, 4'b1111, 32'h01020304, 32'h0, 2'b00, 2, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("resp_q_empty", resp_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
